baud_tick_gen: RTL and testbench
================================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter DIV_W, default 16, width of integer divisor.
REQ-002 Parameter FRAC_W, default 4, width of fractional divisor (units of 1/2^FRAC_W clk).
REQ-003 Parameter OVS, default 16, oversampling ratio; power of two, 4..64.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  generator enable.
REQ-007 sel  input  3  rate select: 0..3 preset 115200/38400/19200/9600, 4..7 custom.
REQ-008 div_int  input  DIV_W  custom integer divisor, os_tick period in clk cycles.
REQ-009 div_frac  input  FRAC_W  custom fractional divisor.
REQ-010 load  input  1  one-cycle request to adopt current sel/div_int/div_frac.
REQ-011 os_tick  output  1  one-cycle pulse at OVS x baud rate.
REQ-012 bit_tick  output  1  one-cycle pulse every OVS os_ticks, coincident with the OVS-th os_tick.
REQ-013 baud_clk  output  1  ~50% square wave at baud rate; toggles on every (OVS/2)-th os_tick.
REQ-014 div_err  output  1  registered flag: active custom div_int < 2.

Function
REQ-015 Active divisor held in shadow regs (int, frac); only changed by reset, load, or en=0.
REQ-016 load with en=1 captures the new divisor into a pending reg; pending moves to active on the next os_tick, never mid-period.
REQ-017 load with en=0 writes the active regs directly, same cycle.
REQ-018 Period counter counts 0..L-1; os_tick is registered, high in the cycle after count==L-1.
REQ-019 Period length L = int + c; c is the carry of acc+frac (FRAC_W+1-bit sum), computed at each wrap; acc keeps the low FRAC_W bits.
REQ-020 Long-run os_tick period = int + frac/2^FRAC_W clk cycles exactly; no accumulated drift.
REQ-021 Sub-tick counter (log2 OVS bits) increments on each os_tick and wraps at OVS-1 -> 0, pulsing bit_tick on the wrap.
REQ-022 Custom int < 2: div_err=1, divisor clamped to int=2, frac=0; div_err clears once a valid divisor is active.
REQ-023 en=0: period counter, sub-tick counter and acc cleared; os_tick, bit_tick, baud_clk held 0.
REQ-024 en 0->1: first os_tick L cycles after the first cycle with en=1.
REQ-025 load and os_tick in the same cycle: the old pending value transfers first; the new value stays pending until the next os_tick.
REQ-026 Counters use DIV_W+1 bits internally; no overflow at int = 2^DIV_W-1 with carry.

Reset
REQ-027 reset sampled on posedge clk; it overrides en and load.
REQ-028 Reset values: counters=0, acc=0, pending empty, active = preset 0 (115200), os_tick=0, bit_tick=0, baud_clk=0, div_err=0.
REQ-029 Reset mid-period aborts the period; no truncated tick is emitted.

Configuration
REQ-030 Macro BAUD_FRAC_EN defined: fractional accumulator present per REQ-019.
REQ-031 BAUD_FRAC_EN undefined: div_frac and preset fractions ignored; acc removed; L = int always.

Structure
REQ-032 Package baud_pkg holds preset int/frac constants (clk=100 MHz, OVS=16), the sel encoding enum and the clamp minimum 2.
REQ-033 Presets at 100 MHz, OVS=16, FRAC_W=4: 54+4/16, 162+12/16, 325+8/16, 651+1/16.
REQ-034 A single sub-module, baud_frac_acc, holds the period counter plus fractional accumulator; the top level holds shadow regs, sub-tick counter and outputs.

Verification
REQ-035 Reset, en=1, sel=0 -> os_tick intervals follow 54,54,54,55 repeating; bit_tick every 16 os_ticks; 1000 os_ticks span 54250 clk cycles.
REQ-036 sel=4, div_int=10, div_frac=0, load while en=0, then en=1 -> first os_tick 10 cycles later; period 10; baud_clk period 160 cycles.
REQ-037 load of sel=3 mid-period at 115200 -> the current period completes at the old length; the next period is 651.
REQ-038 sel=4, div_int=1, load -> div_err=1, period 2; a later load of div_int=5 -> div_err=0 after the adopting os_tick.
REQ-039 reset asserted mid-period with en=1 -> no tick during reset; outputs 0; restart follows REQ-024 timing.
REQ-040 BAUD_FRAC_EN undefined, sel=0 -> every os_tick interval is exactly 54.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants for the baud tick generator (100 MHz clk, OVS=16).
// Fractional presets take effect only when BAUD_FRAC_EN is defined.
package baud_pkg;

  typedef enum logic [2:0] {
    SEL_115200 = 3'd0,
    SEL_38400  = 3'd1,
    SEL_19200  = 3'd2,
    SEL_9600   = 3'd3,
    SEL_CUST0  = 3'd4,
    SEL_CUST1  = 3'd5,
    SEL_CUST2  = 3'd6,
    SEL_CUST3  = 3'd7
  } baud_sel_e;

  localparam int CLAMP_MIN = 2;

  localparam logic [15:0] INT_115200 = 16'd54;
  localparam logic [15:0] INT_38400  = 16'd162;
  localparam logic [15:0] INT_19200  = 16'd325;
  localparam logic [15:0] INT_9600   = 16'd651;

  localparam logic [3:0] FRAC_115200 = 4'd4;
  localparam logic [3:0] FRAC_38400  = 4'd12;
  localparam logic [3:0] FRAC_19200  = 4'd8;
  localparam logic [3:0] FRAC_9600   = 4'd1;

  function automatic logic [15:0] preset_int(
    input baud_sel_e s
  );
    unique case (s)
      SEL_38400: return INT_38400;
      SEL_19200: return INT_19200;
      SEL_9600:  return INT_9600;
      default:   return INT_115200;
    endcase
  endfunction

  function automatic logic [3:0] preset_frac(
    input baud_sel_e s
  );
    unique case (s)
      SEL_38400: return FRAC_38400;
      SEL_19200: return FRAC_19200;
      SEL_9600:  return FRAC_9600;
      default:   return FRAC_115200;
    endcase
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Period counter with fractional carry accumulator.
// Accumulator exists only when BAUD_FRAC_EN is defined.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              wrap
);

  localparam logic [DIV_W:0] ONE = (DIV_W+1)'(1);

  logic [DIV_W:0] cnt;
  logic [DIV_W:0] len;

  assign wrap = en && (cnt == len - ONE);

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  // div_* already carry the divisor for the period about to start
  assign sum = {1'b0, acc} + {1'b0, div_frac};

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      acc <= '0;
      len <= {1'b0, div_int};
    end else if (wrap) begin
      cnt <= '0;
      acc <= sum[FRAC_W-1:0];
      len <= {1'b0, div_int}
           + {{DIV_W{1'b0}}, sum[FRAC_W]};
    end else begin
      cnt <= cnt + ONE;
    end
  end
`else
  logic frac_unused;
  assign frac_unused = ^div_frac;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      len <= {1'b0, div_int};
    end else if (wrap) begin
      cnt <= '0;
      len <= {1'b0, div_int};
    end else begin
      cnt <= cnt + ONE;
    end
  end
`endif

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: shadow divisor regs, sub-tick counter, outputs.
// Define BAUD_FRAC_EN to enable the fractional divisor.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        sel,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              baud_clk,
  output logic              div_err
);

  localparam int SUB_W = $clog2(OVS);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVS/2 - 1);
  localparam logic [DIV_W-1:0] MIN_INT  = DIV_W'(CLAMP_MIN);

  logic [FRAC_W-1:0] cust_frac;
  logic [FRAC_W-1:0] pre_frac;
  logic [FRAC_W-1:0] rst_frac;

`ifdef BAUD_FRAC_EN
  // presets are in 1/16 units; rescale to FRAC_W bits
  function automatic logic [FRAC_W-1:0] scale(
    input logic [3:0] f
  );
    logic [FRAC_W+3:0] w;
    w = {f, {FRAC_W{1'b0}}};
    return w[FRAC_W+3 -: FRAC_W];
  endfunction

  assign cust_frac = div_frac;
  assign pre_frac  = scale(preset_frac(baud_sel_e'(sel)));
  assign rst_frac  = scale(FRAC_115200);
`else
  logic frac_unused;
  assign frac_unused = ^div_frac;
  assign cust_frac   = '0;
  assign pre_frac    = '0;
  assign rst_frac    = '0;
`endif

  logic [DIV_W-1:0]  req_int;
  logic [FRAC_W-1:0] req_frac;
  logic              req_err;

  always_comb begin
    req_int  = MIN_INT;
    req_frac = '0;
    req_err  = 1'b0;
    if (sel[2]) begin
      if (div_int < MIN_INT) begin
        req_err = 1'b1;
      end else begin
        req_int  = div_int;
        req_frac = cust_frac;
      end
    end else begin
      req_int  = DIV_W'(preset_int(baud_sel_e'(sel)));
      req_frac = pre_frac;
    end
  end

  logic [DIV_W-1:0]  act_int,  pend_int,  nxt_int;
  logic [FRAC_W-1:0] act_frac, pend_frac, nxt_frac;
  logic              act_err,  pend_err,  nxt_err;
  logic              pend_vld;
  logic              wrap;

  always_comb begin
    nxt_int  = act_int;
    nxt_frac = act_frac;
    nxt_err  = act_err;
    if (reset) begin
      nxt_int  = DIV_W'(INT_115200);
      nxt_frac = rst_frac;
      nxt_err  = 1'b0;
    end else if (!en && load) begin
      nxt_int  = req_int;
      nxt_frac = req_frac;
      nxt_err  = req_err;
    end else if (pend_vld && (!en || wrap)) begin
      nxt_int  = pend_int;
      nxt_frac = pend_frac;
      nxt_err  = pend_err;
    end
  end

  always_ff @(posedge clk) begin
    act_int  <= nxt_int;
    act_frac <= nxt_frac;
    act_err  <= nxt_err;
    if (reset || !en) begin
      pend_vld <= 1'b0;
    end else if (load) begin
      pend_vld  <= 1'b1;
      pend_int  <= req_int;
      pend_frac <= req_frac;
      pend_err  <= req_err;
    end else if (wrap) begin
      pend_vld <= 1'b0;
    end
  end

  baud_frac_acc #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_int  (nxt_int),
    .div_frac (nxt_frac),
    .wrap     (wrap)
  );

  logic [SUB_W-1:0] sub;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      sub      <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      baud_clk <= 1'b0;
    end else begin
      os_tick  <= wrap;
      bit_tick <= wrap && (sub == SUB_LAST);
      if (wrap) begin
        sub <= sub + SUB_W'(1);
        if (sub == SUB_HALF || sub == SUB_LAST)
          baud_clk <= ~baud_clk;
      end
    end
  end

  assign div_err = act_err;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen.
// Expectations follow BAUD_FRAC_EN when it is defined.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset, en, load;
  logic [2:0]  sel;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, bit_tick, baud_clk, div_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int nticks      = 0;

`ifdef BAUD_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif

  baud_tick_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sel      (sel),
    .div_int  (div_int),
    .div_frac (div_frac),
    .load     (load),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .baud_clk (baud_clk),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_tick(input int budget,
                           output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1) begin
        t = cyc;
        nticks++;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; load = 1'b0;
    sel = 3'd0; div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (os_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_os_tick got %b want 0", os_tick);
    end
    vectors++;
    if (bit_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_bit_tick got %b want 0", bit_tick);
    end
    vectors++;
    if (baud_clk !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_baud_clk got %b want 0", baud_clk);
    end
    vectors++;
    if (div_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_div_err got %b want 0", div_err);
    end
  endtask

  task automatic test_preset_run();
    int c0, t, prev, t1, bad, bterr, exp;
    bad = 0; bterr = 0;
    reset = 1'b0;
    c0 = cyc;
    nticks = 0;
    wait_tick(200, t);
    vectors++;
    if (t - c0 != 54) begin
      miscompares++;
      $display("FAIL first_tick got %0d want 54", t - c0);
    end
    t1 = t; prev = t;
    for (int k = 1; k <= 1000; k++) begin
      wait_tick(200, t);
      if (t < 0) begin
        bad++;
        break;
      end
      exp = 54 + ((FRAC && (k % 4 == 0)) ? 1 : 0);
      if (k <= 8) begin
        vectors++;
        if (t - prev != exp) begin
          miscompares++;
          $display("FAIL interval[%0d] got %0d want %0d",
                   k, t - prev, exp);
        end
      end else if (t - prev != exp) begin
        bad++;
      end
      if (bit_tick !== (nticks % 16 == 0)) bterr++;
      prev = t;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL interval_run got %0d bad want 0", bad);
    end
    vectors++;
    if (bterr != 0) begin
      miscompares++;
      $display("FAIL bit_tick_run got %0d bad want 0", bterr);
    end
    exp = FRAC ? 54250 : 54000;
    vectors++;
    if (t - t1 != exp) begin
      miscompares++;
      $display("FAIL span_1000 got %0d want %0d", t - t1, exp);
    end
  endtask

  task automatic test_preset_switch();
    int t, prev, n, exp;
    wait_tick(200, t);
    prev = t;
    n = nticks;
    repeat (20) @(negedge clk);
    sel = 3'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_tick(200, t);
    exp = 54 + ((FRAC && (n % 4 == 0)) ? 1 : 0);
    vectors++;
    if (t - prev != exp) begin
      miscompares++;
      $display("FAIL switch_old got %0d want %0d", t - prev, exp);
    end
    prev = t;
    wait_tick(1000, t);
    vectors++;
    if (t - prev != 651) begin
      miscompares++;
      $display("FAIL switch_new1 got %0d want 651", t - prev);
    end
    prev = t;
    wait_tick(1000, t);
    vectors++;
    if (t - prev != 651) begin
      miscompares++;
      $display("FAIL switch_new2 got %0d want 651", t - prev);
    end
  endtask

  task automatic test_custom10();
    int c0, ntk, nbt, bt_at, first, r1, r2, f1;
    logic prev;
    ntk = 0; nbt = 0; bt_at = -1; first = -1;
    r1 = -1; r2 = -1; f1 = -1;
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    sel = 3'd4; div_int = 16'd10; div_frac = '0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    c0 = cyc;
    prev = baud_clk;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1) begin
        ntk++;
        if (ntk == 1) first = cyc - c0;
      end
      if (bit_tick === 1'b1) begin
        nbt++;
        bt_at = cyc - c0;
      end
      if (baud_clk === 1'b1 && prev === 1'b0) begin
        if (r1 < 0) r1 = cyc - c0;
        else r2 = cyc - c0;
      end
      if (baud_clk === 1'b0 && prev === 1'b1)
        f1 = cyc - c0;
      prev = baud_clk;
    end
    vectors++;
    if (first != 10) begin
      miscompares++;
      $display("FAIL c10_first got %0d want 10", first);
    end
    vectors++;
    if (ntk != 26) begin
      miscompares++;
      $display("FAIL c10_ticks got %0d want 26", ntk);
    end
    vectors++;
    if (nbt != 1) begin
      miscompares++;
      $display("FAIL c10_nbit got %0d want 1", nbt);
    end
    vectors++;
    if (bt_at != 160) begin
      miscompares++;
      $display("FAIL c10_bit_at got %0d want 160", bt_at);
    end
    vectors++;
    if (r1 != 80) begin
      miscompares++;
      $display("FAIL c10_rise1 got %0d want 80", r1);
    end
    vectors++;
    if (f1 != 160) begin
      miscompares++;
      $display("FAIL c10_fall got %0d want 160", f1);
    end
    vectors++;
    if (r2 - r1 != 160) begin
      miscompares++;
      $display("FAIL c10_period got %0d want 160", r2 - r1);
    end
  endtask

  task automatic test_back_to_back();
    int t, prev;
    wait_tick(30, t);
    repeat (9) @(negedge clk);
    div_int = 16'd6; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (os_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_tick_a got %b want 1", os_tick);
    end
    prev = cyc;
    wait_tick(30, t);
    vectors++;
    if (t - prev != 10) begin
      miscompares++;
      $display("FAIL b2b_hold got %0d want 10", t - prev);
    end
    prev = t;
    wait_tick(30, t);
    vectors++;
    if (t - prev != 6) begin
      miscompares++;
      $display("FAIL b2b_adopt got %0d want 6", t - prev);
    end
    repeat (2) @(negedge clk);
    div_int = 16'd7; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    div_int = 16'd4; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (os_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_tick_b got %b want 1", os_tick);
    end
    prev = cyc;
    wait_tick(30, t);
    vectors++;
    if (t - prev != 7) begin
      miscompares++;
      $display("FAIL b2b_old_pend got %0d want 7", t - prev);
    end
    prev = t;
    wait_tick(30, t);
    vectors++;
    if (t - prev != 4) begin
      miscompares++;
      $display("FAIL b2b_new_pend got %0d want 4", t - prev);
    end
  endtask

  task automatic test_div_err();
    int c0, t, prev;
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    sel = 3'd4; div_int = 16'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (div_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set got %b want 1", div_err);
    end
    en = 1'b1;
    c0 = cyc;
    wait_tick(20, t);
    vectors++;
    if (t - c0 != 2) begin
      miscompares++;
      $display("FAIL err_first got %0d want 2", t - c0);
    end
    prev = t;
    wait_tick(20, t);
    vectors++;
    if (t - prev != 2) begin
      miscompares++;
      $display("FAIL err_period got %0d want 2", t - prev);
    end
    div_int = 16'd5; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vectors++;
    if (div_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_held got %b want 1", div_err);
    end
    @(negedge clk);
    vectors++;
    if (os_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL err_adopt_tick got %b want 1", os_tick);
    end
    vectors++;
    if (div_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got %b want 0", div_err);
    end
    prev = cyc;
    wait_tick(20, t);
    vectors++;
    if (t - prev != 5) begin
      miscompares++;
      $display("FAIL err_new_period got %0d want 5", t - prev);
    end
  endtask

  task automatic test_reset_mid_period();
    int c0, t;
    logic [3:0] outs;
    wait_tick(20, t);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      outs = {os_tick, bit_tick, baud_clk, div_err};
      vectors++;
      if (outs !== 4'b0000) begin
        miscompares++;
        $display("FAIL rst_mid[%0d] got %b want 0000", i, outs);
      end
    end
    reset = 1'b0;
    c0 = cyc;
    wait_tick(200, t);
    vectors++;
    if (t - c0 != 54) begin
      miscompares++;
      $display("FAIL rst_restart got %0d want 54", t - c0);
    end
  endtask

  initial begin
    test_reset();
    test_preset_run();
    test_preset_switch();
    test_custom10();
    test_back_to_back();
    test_div_err();
    test_reset_mid_period();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
